// File: rtl/ic_pkg.sv
// Shared constants and types for the ic_mem_arbiter codebase slice.
package ic_pkg;

  localparam logic IC_ID_S0 = 1'b0;
  localparam logic IC_ID_S1 = 1'b1;

  localparam int unsigned IC_ADDR_W = 32;
  localparam int unsigned IC_DATA_W = 32;
  localparam int unsigned IC_STRB_W = 4;

  typedef enum logic {
    StUnlocked,
    StLocked
  } arb_state_e;

endpackage

// File: rtl/ic_arb_id_fifo.sv
// In-order FIFO of 1-bit requester IDs; remembers which requester owns each outstanding response.
module ic_arb_id_fifo
  import ic_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned PtrW  = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic push_id_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  logic [Depth-1:0] mem_q, mem_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap at Depth, which need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == (PtrW + 1)'(Depth));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= {Depth{IC_ID_S0}};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ic_mem_arbiter.sv
// Two-requester round-robin arbiter with request locking onto one peripheral memory port.
// Optional per-requester stall counters are built when IC_ARB_STALL_CNT_EN is defined.
module ic_mem_arbiter
  import ic_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ID_PTR_W        = 1
) (
  input  logic                 g_clk,
  input  logic                 g_reset,

  input  logic                 s0_req,
  input  logic                 s0_wen,
  input  logic [IC_STRB_W-1:0] s0_strb,
  input  logic [IC_DATA_W-1:0] s0_wdata,
  input  logic [IC_ADDR_W-1:0] s0_addr,
  output logic                 s0_gnt,
  output logic                 s0_recv,
  input  logic                 s0_ack,
  output logic                 s0_error,
  output logic [IC_DATA_W-1:0] s0_rdata,

  input  logic                 s1_req,
  input  logic                 s1_wen,
  input  logic [IC_STRB_W-1:0] s1_strb,
  input  logic [IC_DATA_W-1:0] s1_wdata,
  input  logic [IC_ADDR_W-1:0] s1_addr,
  output logic                 s1_gnt,
  output logic                 s1_recv,
  input  logic                 s1_ack,
  output logic                 s1_error,
  output logic [IC_DATA_W-1:0] s1_rdata,

  output logic                 p_req,
  output logic                 p_wen,
  output logic [IC_STRB_W-1:0] p_strb,
  output logic [IC_DATA_W-1:0] p_wdata,
  output logic [IC_ADDR_W-1:0] p_addr,
  input  logic                 p_gnt,
  input  logic                 p_recv,
  output logic                 p_ack,
  input  logic                 p_error,
  input  logic [IC_DATA_W-1:0] p_rdata
`ifdef IC_ARB_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cnt_s0,
  output logic [31:0]          stall_cnt_s1
`endif
);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       rr_last_q, rr_last_d;

  logic sel, sel_req, accept, fifo_pop;
  logic fifo_full, fifo_empty, fifo_head;
  logic head_s0, head_s1;

  always_comb begin
    if (state_q == StLocked) begin
      sel = owner_q;
    end else if (s0_req && !s1_req) begin
      sel = IC_ID_S0;
    end else if (s1_req && !s0_req) begin
      sel = IC_ID_S1;
    end else begin
      sel = ~rr_last_q;
    end
  end

  // Request path: pure steering from sel, blocked while the ID FIFO is full.
  always_comb begin
    if (sel == IC_ID_S1) begin
      sel_req = s1_req;
      p_wen   = s1_wen;
      p_strb  = s1_strb;
      p_wdata = s1_wdata;
      p_addr  = s1_addr;
    end else begin
      sel_req = s0_req;
      p_wen   = s0_wen;
      p_strb  = s0_strb;
      p_wdata = s0_wdata;
      p_addr  = s0_addr;
    end
    p_req  = !g_reset && sel_req && !fifo_full;
    accept = p_req && p_gnt;
    s0_gnt = accept && (sel == IC_ID_S0);
    s1_gnt = accept && (sel == IC_ID_S1);
  end

  // Response path: the FIFO head decides who sees the peripheral response.
  always_comb begin
    head_s0  = !fifo_empty && (fifo_head == IC_ID_S0);
    head_s1  = !fifo_empty && (fifo_head == IC_ID_S1);
    s0_recv  = !g_reset && p_recv && head_s0;
    s1_recv  = !g_reset && p_recv && head_s1;
    s0_error = head_s0 && p_error;
    s1_error = head_s1 && p_error;
    s0_rdata = head_s0 ? p_rdata : '0;
    s1_rdata = head_s1 ? p_rdata : '0;
    p_ack    = !g_reset && ((head_s0 && s0_ack) || (head_s1 && s1_ack));
    fifo_pop = p_recv && p_ack;
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    if (accept) begin
      state_d   = StUnlocked;
      rr_last_d = sel;
    end else if (p_req) begin
      state_d = StLocked;
      owner_d = sel;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q   <= StUnlocked;
      owner_q   <= IC_ID_S0;
      rr_last_q <= IC_ID_S1;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
    end
  end

  ic_arb_id_fifo #(
    .Depth (MAX_OUTSTANDING),
    .PtrW  (ID_PTR_W)
  ) u_id_fifo (
    .clk_i     (g_clk),
    .rst_i     (g_reset),
    .push_i    (accept),
    .push_id_i (sel),
    .pop_i     (fifo_pop),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .head_o    (fifo_head)
  );

`ifdef IC_ARB_STALL_CNT_EN
  logic [31:0] stall_s0_q, stall_s0_d;
  logic [31:0] stall_s1_q, stall_s1_d;

  always_comb begin
    stall_s0_d = stall_s0_q;
    stall_s1_d = stall_s1_q;
    if (s0_req && !s0_gnt && (stall_s0_q != 32'hFFFF_FFFF)) begin
      stall_s0_d = stall_s0_q + 32'd1;
    end
    if (s1_req && !s1_gnt && (stall_s1_q != 32'hFFFF_FFFF)) begin
      stall_s1_d = stall_s1_q + 32'd1;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      stall_s0_q <= '0;
      stall_s1_q <= '0;
    end else begin
      stall_s0_q <= stall_s0_d;
      stall_s1_q <= stall_s1_d;
    end
  end

  assign stall_cnt_s0 = stall_s0_q;
  assign stall_cnt_s1 = stall_s1_q;
`endif

endmodule

// File: tb/tb_ic_mem_arbiter.sv
// Directed bench for ic_mem_arbiter: a queue-based model checked every cycle plus literal checks.
module tb_ic_mem_arbiter;

  localparam int MaxOut = 2;

  logic        g_clk = 1'b0;
  logic        g_reset = 1'b1;
  logic        s0_req = 0, s0_wen = 0, s0_ack = 0;
  logic        s1_req = 0, s1_wen = 0, s1_ack = 0;
  logic [3:0]  s0_strb = 0, s1_strb = 0;
  logic [31:0] s0_wdata = 0, s1_wdata = 0, s0_addr = 0, s1_addr = 0;
  logic        s0_gnt, s0_recv, s0_error, s1_gnt, s1_recv, s1_error;
  logic [31:0] s0_rdata, s1_rdata;
  logic        p_req, p_wen, p_ack;
  logic [3:0]  p_strb;
  logic [31:0] p_wdata, p_addr;
  logic        p_gnt = 0, p_recv = 0, p_error = 0;
  logic [31:0] p_rdata = 0;
`ifdef IC_ARB_STALL_CNT_EN
  logic [31:0] stall_cnt_s0, stall_cnt_s1;
`endif

  int checks = 0;
  int failures = 0;

  always #5 g_clk = ~g_clk;

  ic_mem_arbiter #(
    .MAX_OUTSTANDING (MaxOut),
    .ID_PTR_W        (1)
  ) dut (
    .g_clk    (g_clk),    .g_reset  (g_reset),
    .s0_req   (s0_req),   .s0_wen   (s0_wen),   .s0_strb  (s0_strb),
    .s0_wdata (s0_wdata), .s0_addr  (s0_addr),  .s0_gnt   (s0_gnt),
    .s0_recv  (s0_recv),  .s0_ack   (s0_ack),   .s0_error (s0_error),
    .s0_rdata (s0_rdata),
    .s1_req   (s1_req),   .s1_wen   (s1_wen),   .s1_strb  (s1_strb),
    .s1_wdata (s1_wdata), .s1_addr  (s1_addr),  .s1_gnt   (s1_gnt),
    .s1_recv  (s1_recv),  .s1_ack   (s1_ack),   .s1_error (s1_error),
    .s1_rdata (s1_rdata),
    .p_req    (p_req),    .p_wen    (p_wen),    .p_strb   (p_strb),
    .p_wdata  (p_wdata),  .p_addr   (p_addr),   .p_gnt    (p_gnt),
    .p_recv   (p_recv),   .p_ack    (p_ack),    .p_error  (p_error),
    .p_rdata  (p_rdata)
`ifdef IC_ARB_STALL_CNT_EN
    ,
    .stall_cnt_s0 (stall_cnt_s0),
    .stall_cnt_s1 (stall_cnt_s1)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of owner IDs in issue order, plus the pending (locked) requester and last winner.
  logic m_q[$];
  int   m_owner = -1;
  logic m_last = 1'b1;
  logic [31:0] m_stall0 = 0, m_stall1 = 0;

  function automatic logic m_sel();
    if (m_owner >= 0) return m_owner[0];
    if (s0_req && !s1_req) return 1'b0;
    if (s1_req && !s0_req) return 1'b1;
    return !m_last;
  endfunction

  function automatic logic m_preq();
    logic s;
    s = m_sel();
    return !g_reset && (s ? s1_req : s0_req) && (m_q.size() < MaxOut);
  endfunction

  function automatic logic m_head_is(input logic id);
    return (m_q.size() > 0) && (m_q[0] == id);
  endfunction

  function automatic logic m_pack();
    if (g_reset || m_q.size() == 0) return 1'b0;
    return m_q[0] ? s1_ack : s0_ack;
  endfunction

  always @(posedge g_clk) begin
    logic s, pr, pop;
    if (g_reset) begin
      m_q.delete();
      m_owner  = -1;
      m_last   = 1'b1;
      m_stall0 = 0;
      m_stall1 = 0;
    end else begin
      s   = m_sel();
      pr  = m_preq();
      pop = p_recv && m_pack();
      if (s0_req && !(pr && p_gnt && !s) && m_stall0 != 32'hFFFF_FFFF) m_stall0++;
      if (s1_req && !(pr && p_gnt && s) && m_stall1 != 32'hFFFF_FFFF) m_stall1++;
      if (pop) void'(m_q.pop_front());
      if (pr && p_gnt) begin
        m_q.push_back(s);
        m_last  = s;
        m_owner = -1;
      end else if (pr) begin
        m_owner = int'(s);
      end
    end
  end

  always @(negedge g_clk) begin
    logic s, pr;
    s  = m_sel();
    pr = m_preq();
    check("p_req", 32'(p_req), 32'(pr));
    if (pr) begin
      check("p_addr", p_addr, s ? s1_addr : s0_addr);
      check("p_wdata", p_wdata, s ? s1_wdata : s0_wdata);
      check("p_wen", 32'(p_wen), 32'(s ? s1_wen : s0_wen));
      check("p_strb", 32'(p_strb), 32'(s ? s1_strb : s0_strb));
    end
    check("s0_gnt", 32'(s0_gnt), 32'(pr && p_gnt && !s));
    check("s1_gnt", 32'(s1_gnt), 32'(pr && p_gnt && s));
    check("s0_recv", 32'(s0_recv), 32'(!g_reset && p_recv && m_head_is(1'b0)));
    check("s1_recv", 32'(s1_recv), 32'(!g_reset && p_recv && m_head_is(1'b1)));
    check("s0_rdata", s0_rdata, m_head_is(1'b0) ? p_rdata : 32'h0);
    check("s1_rdata", s1_rdata, m_head_is(1'b1) ? p_rdata : 32'h0);
    check("s0_error", 32'(s0_error), 32'(m_head_is(1'b0) && p_error));
    check("s1_error", 32'(s1_error), 32'(m_head_is(1'b1) && p_error));
    check("p_ack", 32'(p_ack), 32'(m_pack()));
`ifdef IC_ARB_STALL_CNT_EN
    check("stall_cnt_s0", stall_cnt_s0, m_stall0);
    check("stall_cnt_s1", stall_cnt_s1, m_stall1);
`endif
  end

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic clear_inputs();
    s0_req = 0; s1_req = 0; s0_ack = 0; s1_ack = 0; s0_wen = 0; s1_wen = 0;
    p_gnt = 0; p_recv = 0; p_error = 0; p_rdata = 0;
  endtask

  task automatic do_reset();
    tick();
    g_reset = 1;
    clear_inputs();
    tick();
    g_reset = 0;
  endtask

  initial begin
    s0_addr = 32'h2000_0010; s0_wdata = 32'hA0A0_0000; s0_strb = 4'hF;
    s1_addr = 32'h3000_0020; s1_wdata = 32'hB1B1_1111; s1_strb = 4'h3;

    // Outputs forced low during reset even with a requester and a ready peripheral.
    tick();
    s0_req = 1; p_gnt = 1;
    #1;
    check("rst_p_req", 32'(p_req), 32'h0);
    check("rst_s0_gnt", 32'(s0_gnt), 32'h0);
    tick();
    g_reset = 0;
    clear_inputs();

    // Single s0 read with error flag on the response.
    tick();
    s0_req = 1; p_gnt = 1;
    #1;
    check("t1_p_addr", p_addr, 32'h2000_0010);
    check("t1_s0_gnt", 32'(s0_gnt), 32'h1);
    tick();
    s0_req = 0; p_gnt = 0; p_recv = 1; p_rdata = 32'hDEAD_BEEF; p_error = 1; s0_ack = 1;
    #1;
    check("t1_s0_recv", 32'(s0_recv), 32'h1);
    check("t1_s0_rdata", s0_rdata, 32'hDEAD_BEEF);
    check("t1_s0_error", 32'(s0_error), 32'h1);
    check("t1_s1_recv", 32'(s1_recv), 32'h0);
    check("t1_p_ack", 32'(p_ack), 32'h1);
    tick();
    clear_inputs();

    // Round-robin alternation from reset: s0, s1, s0, s1.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      s0_req = 1; s1_req = 1; p_gnt = 1; s0_ack = 1; s1_ack = 1;
      p_recv = (i > 0); p_rdata = 32'(100 + i);
      #1;
      check("rr_s0_gnt", 32'(s0_gnt), 32'((i % 2) == 0));
      check("rr_s1_gnt", 32'(s1_gnt), 32'((i % 2) == 1));
      tick();
    end
    s0_req = 0; s1_req = 0; p_gnt = 0; p_recv = 1;
    tick();
    clear_inputs();

    // Lock: peripheral stalls 4 cycles, address must stay on s0 throughout.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      s0_req = 1; s1_req = 1; p_gnt = (i == 4);
      #1;
      check("lock_p_addr", p_addr, 32'h2000_0010);
      check("lock_s0_gnt", 32'(s0_gnt), 32'(i == 4));
      check("lock_s1_gnt", 32'(s1_gnt), 32'h0);
      tick();
    end
    s0_req = 0; s1_req = 0; p_gnt = 0; p_recv = 1; s0_ack = 1;
`ifdef IC_ARB_STALL_CNT_EN
    #1;
    check("stall_s1_lit", stall_cnt_s1, 32'd5);
    check("stall_s0_lit", stall_cnt_s0, 32'd4);
`endif
    tick();
    clear_inputs();

    // Full FIFO: s1 then s0 accepted, responses held back.
    do_reset();
    s1_req = 1; p_gnt = 1;
    tick();
    s1_req = 0; s0_req = 1;
    #1;
    check("full_acc_s0", 32'(s0_gnt), 32'h1);
    tick();
    #1;
    check("full_p_req", 32'(p_req), 32'h0);
    check("full_s0_gnt", 32'(s0_gnt), 32'h0);
    tick();
    p_recv = 1; p_rdata = 32'h11; s1_ack = 1;
    #1;
    check("full_pop_s0_gnt", 32'(s0_gnt), 32'h0);
    check("full_s1_recv", 32'(s1_recv), 32'h1);
    check("full_s1_rdata", s1_rdata, 32'h11);
    tick();
    p_rdata = 32'h22; s1_ack = 0; s0_ack = 1;
    #1;
    check("after_pop_s0_gnt", 32'(s0_gnt), 32'h1);
    check("full_s0_rdata", s0_rdata, 32'h22);
    check("full_s1_recv2", 32'(s1_recv), 32'h0);
    tick();
    s0_req = 0; p_gnt = 0; p_rdata = 32'h33;
    tick();
    clear_inputs();

    // Reset with one transaction outstanding; stale response afterwards is ignored.
    do_reset();
    s0_req = 1; p_gnt = 1;
    tick();
    s0_req = 0; p_gnt = 0; g_reset = 1; p_recv = 1; s0_ack = 1; p_rdata = 32'h44;
    #1;
    check("mid_rst_p_ack", 32'(p_ack), 32'h0);
    check("mid_rst_s0_recv", 32'(s0_recv), 32'h0);
    tick();
    g_reset = 0;
    #1;
    check("post_rst_s0_recv", 32'(s0_recv), 32'h0);
    check("post_rst_p_ack", 32'(p_ack), 32'h0);
    tick();
    clear_inputs();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ic_mem_arbiter.md
Name: ic_mem_arbiter

Overview:
- Shares one peripheral memory port (e.g. RAM) between two CPU-side requesters: s0 = instruction fetch, s1 = data access.
- Sits between the CPU-side address-decode/routing layer and a single peripheral port, so imem and dmem can both reach the same RAM.
- Round-robin arbitration with request locking. An in-order ID FIFO steers each response back to the requester that issued it.

Parameters:
- MAX_OUTSTANDING, 2, maximum number of accepted requests awaiting a response (1..4).
- ID_PTR_W, 1, FIFO pointer width; must be clog2(MAX_OUTSTANDING), minimum 1.

Ports:
- g_clk  in  1  clock
- g_reset  in  1  synchronous reset, active-high
- s0_req, s1_req  in  1  requester start request; held until gnt
- s0_wen, s1_wen  in  1  write enable
- s0_strb, s1_strb  in  4  write strobe
- s0_wdata, s1_wdata  in  32  write data
- s0_addr, s1_addr  in  32  address
- s0_gnt, s1_gnt  out  1  request accepted
- s0_recv, s1_recv  out  1  response valid
- s0_ack, s1_ack  in  1  requester accepts response
- s0_error, s1_error  out  1  response error
- s0_rdata, s1_rdata  out  32  read data
- p_req  out  1  peripheral request
- p_wen  out  1  write enable
- p_strb  out  4  write strobe
- p_wdata  out  32  write data
- p_addr  out  32  address
- p_gnt  in  1  peripheral accepted request
- p_recv  in  1  peripheral response valid
- p_ack  out  1  response accepted
- p_error  in  1  response error
- p_rdata  in  32  read data

Behaviour:
- Handshakes:
  - A request transfers in a cycle where p_req && p_gnt.
  - A response transfers in a cycle where p_recv && p_ack.
  - The peripheral presents a response no earlier than the cycle after its acceptance.
- Reset (g_reset=1, sampled at posedge):
  - FIFO emptied, count=0, lock cleared, rr_last=1 (s0 wins the first tie).
  - While g_reset is high, all outputs are forced to 0: p_req, p_ack, s*_gnt, s*_recv.
  - Reset mid-transaction discards outstanding IDs; the peripheral is reset in the same cycle.
- Arbitration state machine, states UNLOCKED and LOCKED(owner):
  - UNLOCKED: sel = the only requester asserting req; if both assert, sel = !rr_last.
  - LOCKED(owner): sel = owner regardless of the other req.
  - UNLOCKED -> LOCKED(sel) when p_req && !p_gnt.
  - LOCKED -> UNLOCKED on acceptance (p_req && p_gnt).
  - On every acceptance, rr_last <= sel.
  - The lock guarantees p_addr/p_wdata do not switch source while p_req is pending.
- Request path (combinational from sel):
  - p_req = s[sel]_req && !full.
  - p_wen/strb/wdata/addr = s[sel] fields.
  - s[sel]_gnt = p_gnt && p_req; the other requester's gnt = 0.
- Full: count==MAX_OUTSTANDING forces p_req=0. A same-cycle pop does not reopen the grant, so there is no combinational ack->gnt path.
- ID FIFO:
  - Push sel on acceptance; pop head on response transfer.
  - Simultaneous push and pop: count unchanged, both pointers advance, wrapping at MAX_OUTSTANDING.
- Response path:
  - s[head]_recv = p_recv && !empty; s[head]_error = p_error; s[head]_rdata = p_rdata.
  - The non-head requester sees recv=0, error=0, rdata=0.
  - p_ack = s[head]_ack && !empty.
  - p_recv while empty: ignored, p_ack=0.
- Latency: zero added cycles on both request and response paths; pure combinational steering plus state.

Optional Feature:
- Macro IC_ARB_STALL_CNT_EN.
- When defined:
  - Adds outputs stall_cnt_s0 and stall_cnt_s1, 32-bit each.
  - Each counts cycles where s*_req=1 && s*_gnt=0.
  - Counters saturate at 32'hFFFF_FFFF and clear on g_reset.
- When undefined: no ports, no counter logic. Arbitration behaviour is identical in both builds.

Decomposition:
- Shared package ic_pkg holds:
  - IC_ID_S0=1'b0, IC_ID_S1=1'b1.
  - IC_ADDR_W=32, IC_DATA_W=32, IC_STRB_W=4.
- Natural sub-module: ic_arb_id_fifo, a 1-bit-wide FIFO of depth MAX_OUTSTANDING with push/pop/full/empty/head and a synchronous active-high reset.

Test Plan:
- s0_req=1 alone, addr=32'h2000_0010, p_gnt=1 -> p_addr=32'h2000_0010, s0_gnt=1 same cycle. Next cycle p_recv=1, p_rdata=32'hDEAD_BEEF -> s0_recv=1, s0_rdata=32'hDEAD_BEEF, s1_recv=0; s0_ack=1 -> p_ack=1.
- s0_req and s1_req both held, p_gnt=1 each cycle, responses returned promptly -> grants alternate s0,s1,s0,s1 starting with s0 after reset.
- Both req, p_gnt=0 for 3 cycles, then 1 -> p_addr stays s0_addr for all 4 cycles; s0_gnt asserted on cycle 4 only; s1_gnt never asserted in that window.
- MAX_OUTSTANDING=2, two accepts (s1 then s0) with p_recv held 0 -> p_req=0 while full. Release responses 0x11, 0x22 -> s1_rdata=0x11 first, then s0_rdata=0x22.
- Full FIFO with response pop and a pending s0_req in the same cycle -> no grant that cycle; s0_gnt=1 the next cycle.
- g_reset=1 with one outstanding transaction -> p_ack=0, s*_recv=0; after release, p_recv=1 is ignored.
- With IC_ARB_STALL_CNT_EN defined: s1 blocked for 5 cycles behind an s0 lock -> stall_cnt_s1=5.
